// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern generator: rotate, ping-pong and fill/clear with prescaled step rate
module led_pattern_gen #(
    parameter int LED_NUM     = 4,
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [1:0]         mode,
    input  logic [1:0]         speed,
    input  logic               pause,
    output logic [LED_NUM-1:0] led,
    output logic               step_pulse
);

    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [LED_NUM-1:0] START = LED_NUM'(1);

    logic [CW-1:0]      cnt;
    logic [1:0]         mode_q;
    logic               dir;

    logic [31:0]        period;
    logic [31:0]        term;
    logic               at_term;
    logic [LED_NUM-1:0] led_nxt;
    logic               dir_nxt;

    // Compare with >= so a speed increase with cnt past the new terminal steps at once.
    always_comb begin
        period  = 32'(STEP_CYCLES) >> speed;
        term    = period - 32'd1;
        at_term = 32'(cnt) >= term;
    end

    always_comb begin
        led_nxt = led;
        dir_nxt = dir;
        case (mode_q)
            2'd0: led_nxt = {led[LED_NUM-2:0], led[LED_NUM-1]};
            2'd1: led_nxt = {led[0], led[LED_NUM-1:1]};
            2'd2: begin
                if (!dir) begin
                    led_nxt = led << 1;
                    if (led_nxt[LED_NUM-1]) dir_nxt = 1'b1;
                end else begin
                    led_nxt = led >> 1;
                    if (led_nxt[0]) dir_nxt = 1'b0;
                end
            end
            default: led_nxt = (&led) ? '0 : {led[LED_NUM-2:0], 1'b1};
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            led        <= START;
            cnt        <= '0;
            dir        <= 1'b0;
            mode_q     <= mode;
            step_pulse <= 1'b0;
        end else if (mode != mode_q) begin
            // A mode change restarts the pattern even while paused.
            mode_q     <= mode;
            led        <= START;
            cnt        <= '0;
            dir        <= 1'b0;
            step_pulse <= 1'b0;
        end else if (pause) begin
            step_pulse <= 1'b0;
        end else if (at_term) begin
            cnt        <= '0;
            led        <= led_nxt;
            dir        <= dir_nxt;
            step_pulse <= 1'b1;
        end else begin
            cnt        <= cnt + CW'(1);
            step_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen with table vectors and a reference model
module tb_led_pattern_gen;

    localparam int N    = 4;
    localparam int STEP = 8;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic [1:0]   mode;
    logic [1:0]   speed;
    logic         pause;
    logic [N-1:0] led;
    logic         step_pulse;

    int tests = 0;
    int fails = 0;

    // Reference model: pattern index k within the mode's sequence and cycles elapsed since last step.
    int       m_k;
    int       m_el;
    logic [1:0] m_mq;
    logic     m_sp;

    typedef struct {
        logic [1:0]   mode;
        logic [1:0]   speed;
        int           edges;
        logic [N-1:0] led;
        logic         sp;
    } vec_t;

    vec_t tbl[$];

    led_pattern_gen #(.LED_NUM(N), .STEP_CYCLES(STEP)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .mode       (mode),
        .speed      (speed),
        .pause      (pause),
        .led        (led),
        .step_pulse (step_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [N-1:0] pat(input logic [1:0] m, input int k);
        int p;
        int f;
        logic [N-1:0] one;
        one = 1;
        case (m)
            2'd0: return one << (k % N);
            2'd1: return one << ((N - (k % N)) % N);
            2'd2: begin
                p = k % (2 * N - 2);
                return (p < N) ? one << p : one << (2 * N - 2 - p);
            end
            default: begin
                f = (k % (N + 1)) + 1;
                return (f <= N) ? N'((1 << f) - 1) : '0;
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [N-1:0] a_led, input logic a_sp,
                         input logic [N-1:0] e_led, input logic e_sp);
        tests++;
        if (a_led !== e_led || a_sp !== e_sp) begin
            fails++;
            $display("FAIL %s @%0t: led=%b step_pulse=%b, expected led=%b step_pulse=%b",
                     name, $time, a_led, a_sp, e_led, e_sp);
        end
    endtask

    task automatic tick();
        int per;
        @(posedge sys_clk);
        per = STEP >> speed;
        if (sys_rst) begin
            m_k = 0; m_el = 0; m_mq = mode; m_sp = 1'b0;
        end else if (mode != m_mq) begin
            m_k = 0; m_el = 0; m_mq = mode; m_sp = 1'b0;
        end else if (pause) begin
            m_sp = 1'b0;
        end else if (m_el >= per - 1) begin
            m_el = 0; m_k++; m_sp = 1'b1;
        end else begin
            m_el++; m_sp = 1'b0;
        end
        @(negedge sys_clk);
        check("model", led, step_pulse, pat(m_mq, m_k), m_sp);
    endtask

    task automatic do_reset(input logic [1:0] m);
        sys_rst = 1'b1;
        mode    = m;
        pause   = 1'b0;
        repeat (3) tick();
        check("reset", led, step_pulse, 4'b0001, 1'b0);
        sys_rst = 1'b0;
    endtask

    task automatic add(input logic [1:0] m, input logic [1:0] s, input int e,
                       input logic [N-1:0] l, input logic sp);
        vec_t v;
        v.mode = m; v.speed = s; v.edges = e; v.led = l; v.sp = sp;
        tbl.push_back(v);
    endtask

    initial begin
        sys_rst = 1'b1;
        mode    = 2'd0;
        speed   = 2'd0;
        pause   = 1'b0;

        // Reset release, first step on 8th edge, then every 8; then all four patterns at speed 3.
        add(0, 0, 7, 4'b0001, 0);
        add(0, 0, 1, 4'b0010, 1);
        add(0, 0, 1, 4'b0010, 0);
        add(0, 0, 7, 4'b0100, 1);
        add(0, 3, 1, 4'b1000, 1);
        add(0, 3, 1, 4'b0001, 1);
        add(1, 3, 1, 4'b0001, 0);
        add(1, 3, 1, 4'b1000, 1);
        add(1, 3, 1, 4'b0100, 1);
        add(1, 3, 1, 4'b0010, 1);
        add(1, 3, 1, 4'b0001, 1);
        add(2, 3, 1, 4'b0001, 0);
        add(2, 3, 1, 4'b0010, 1);
        add(2, 3, 1, 4'b0100, 1);
        add(2, 3, 1, 4'b1000, 1);
        add(2, 3, 1, 4'b0100, 1);
        add(2, 3, 1, 4'b0010, 1);
        add(2, 3, 1, 4'b0001, 1);
        add(2, 3, 1, 4'b0010, 1);
        add(3, 3, 1, 4'b0001, 0);
        add(3, 3, 1, 4'b0011, 1);
        add(3, 3, 1, 4'b0111, 1);
        add(3, 3, 1, 4'b1111, 1);
        add(3, 3, 1, 4'b0000, 1);
        add(3, 3, 1, 4'b0001, 1);

        do_reset(2'd0);
        foreach (tbl[i]) begin
            mode  = tbl[i].mode;
            speed = tbl[i].speed;
            repeat (tbl[i].edges) tick();
            check($sformatf("vec%0d", i), led, step_pulse, tbl[i].led, tbl[i].sp);
        end

        // Speed 0 -> 2 with cnt at 6: immediate step, then every 2 cycles.
        do_reset(2'd0);
        speed = 2'd0;
        repeat (6) tick();
        speed = 2'd2;
        tick(); check("spd_switch", led, step_pulse, 4'b0010, 1'b1);
        tick(); check("spd_gap",    led, step_pulse, 4'b0010, 1'b0);
        tick(); check("spd_next",   led, step_pulse, 4'b0100, 1'b1);

        // Pause for 20 cycles at cnt 3: frozen, then the remaining 5 unpaused edges complete the period.
        do_reset(2'd0);
        speed = 2'd0;
        repeat (3) tick();
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(); check("pause_hold", led, step_pulse, 4'b0001, 1'b0);
        end
        pause = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); check("resume_wait", led, step_pulse, 4'b0001, 1'b0);
        end
        tick(); check("resume_step", led, step_pulse, 4'b0010, 1'b1);

        // Mode change while paused restarts the pattern.
        do_reset(2'd0);
        speed = 2'd3;
        tick();
        tick(); check("pre_mode", led, step_pulse, 4'b0100, 1'b1);
        pause = 1'b1;
        mode  = 2'd3;
        tick(); check("mode_paused", led, step_pulse, 4'b0001, 1'b0);
        tick(); check("mode_hold",   led, step_pulse, 4'b0001, 1'b0);
        pause = 1'b0;
        tick(); check("mode_resume", led, step_pulse, 4'b0011, 1'b1);

        // Reset mid-period.
        do_reset(2'd0);
        speed = 2'd0;
        repeat (24) tick();
        check("pre_rst", led, step_pulse, 4'b1000, 1'b1);
        repeat (3) tick();
        sys_rst = 1'b1;
        tick(); check("mid_rst", led, step_pulse, 4'b0001, 1'b0);
        sys_rst = 1'b0;

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            sys_rst = ($urandom % 200) == 0;
            if (($urandom % 40) == 0) mode = 2'($urandom_range(0, 3));
            if (($urandom % 30) == 0) speed = 2'($urandom_range(0, 3));
            pause = ($urandom % 10) == 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
